// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam int   PC_INC            = 4;
    localparam logic RST_RADDR_VALID   = 1'b0;
    localparam logic RST_RDATA_READY   = 1'b0;
    localparam logic RST_MISALIGNED    = 1'b0;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return |lo;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus: address channel out, data channel back.
interface fetch_unit_if #(
    parameter int pc_width   = 32,
    parameter int inst_width = 32
);
    logic                  i_raddr_valid;
    logic                  i_raddr_ready;
    logic [pc_width-1:0]   i_raddr;
    logic                  i_rdata_valid;
    logic                  i_rdata_ready;
    logic [inst_width-1:0] i_rdata;

    modport master (
        output i_raddr_valid, i_raddr, i_rdata_ready,
        input  i_raddr_ready, i_rdata_valid, i_rdata
    );

    modport slave (
        input  i_raddr_valid, i_raddr, i_rdata_ready,
        output i_raddr_ready, i_rdata_valid, i_rdata
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head is read straight from storage registers.
module fetch_fifo #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [width-1:0]             din,
    output logic [width-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(depth+1)-1:0]   count
);
    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth+1);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign full    = (count == CW'(depth));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push & (~full | pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch with redirect/drain.
// Optional FETCH_MISALIGN_CHECK_EN: flag and align misaligned redirect targets.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  pc_width   = 32,
    parameter logic [pc_width-1:0] pc_init    = '0,
    parameter int                  inst_width = 32,
    parameter int                  buf_depth  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_unit_if.master          bus,
    input  logic                  redirect,
    input  logic [pc_width-1:0]   redirect_pc,
    output logic [inst_width-1:0] inst,
    output logic [pc_width-1:0]   inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  fetch_misaligned
);
    localparam int CW = $clog2(buf_depth+1);

    logic rst_meta, rst_sync;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rst_meta, rst_sync} <= 2'b00;
        else      {rst_meta, rst_sync} <= {1'b1, rst_meta};
    end

    fetch_state_e        state, state_nxt;
    logic [pc_width-1:0] pc, raddr, pc_base, target;
    logic                raddr_valid, rdata_ready, stale, stale_next;
    logic [CW-1:0]       outstanding, discard, out_next, disc_next, bcount, bc_next;
    logic [CW:0]         occ_next;
    logic                addr_xfer, data_xfer, keep, pop_buf, hold, issue, mis_set;

    logic [pc_width-1:0] af_head;
    logic                af_full, af_empty, buf_full, buf_empty;
    logic [CW-1:0]       af_count;
    logic [pc_width+inst_width-1:0] buf_head;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target  = {redirect_pc[pc_width-1:2], 2'b00};
    assign mis_set = redirect & is_misaligned(redirect_pc[1:0]);
`else
    assign target  = redirect_pc;
    assign mis_set = 1'b0;
`endif

    always_comb begin
        addr_xfer = raddr_valid & bus.i_raddr_ready;
        data_xfer = bus.i_rdata_valid & rdata_ready & (outstanding != '0);
        hold      = raddr_valid & ~addr_xfer;
        // responses for discarded requests are the oldest in flight, so they drop first
        keep      = data_xfer & (discard == '0) & ~redirect;
        pop_buf   = inst_valid & inst_ready & ~redirect;
        out_next  = outstanding + CW'(addr_xfer) - CW'(data_xfer);
        bc_next   = redirect ? '0 : bcount + CW'(keep) - CW'(pop_buf);
        if (redirect) begin
            disc_next  = out_next;
            stale_next = hold;
        end else begin
            disc_next  = discard + CW'(addr_xfer & stale) - CW'(data_xfer & (discard != '0));
            stale_next = stale & ~addr_xfer;
        end
        pc_base  = redirect ? target : pc;
        occ_next = {1'b0, out_next} + {1'b0, bc_next};

        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_RUN;
            ST_RUN:   if (redirect && (out_next != '0 || hold)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (disc_next == '0 && !stale_next) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase

        issue = ~hold & (state_nxt == ST_RUN) & (occ_next < (CW+1)'(buf_depth));
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state       <= ST_IDLE;
            pc          <= pc_init;
            raddr       <= pc_init;
            raddr_valid <= RST_RADDR_VALID;
            rdata_ready <= RST_RDATA_READY;
            outstanding <= '0;
            discard     <= '0;
            stale       <= 1'b0;
        end else begin
            state       <= state_nxt;
            rdata_ready <= 1'b1;
            outstanding <= out_next;
            discard     <= disc_next;
            stale       <= stale_next;
            if (issue) begin
                raddr_valid <= 1'b1;
                raddr       <= pc_base;
                pc          <= pc_base + pc_width'(PC_INC);
            end else begin
                raddr_valid <= hold;
                pc          <= pc_base;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) misaligned <= RST_MISALIGNED;
        else           misaligned <= misaligned | mis_set;
    end
    assign fetch_misaligned = misaligned;
`else
    assign fetch_misaligned = RST_MISALIGNED | mis_set;
`endif

    assign bus.i_raddr_valid = raddr_valid;
    assign bus.i_raddr       = raddr;
    assign bus.i_rdata_ready = rdata_ready;

    fetch_fifo #(.width(pc_width), .depth(buf_depth)) u_addr_fifo (
        .clk   (clk),
        .rst   (rst_sync),
        .clr   (1'b0),
        .push  (addr_xfer),
        .pop   (data_xfer),
        .din   (raddr),
        .dout  (af_head),
        .full  (af_full),
        .empty (af_empty),
        .count (af_count)
    );

    fetch_fifo #(.width(pc_width+inst_width), .depth(buf_depth)) u_inst_buf (
        .clk   (clk),
        .rst   (rst_sync),
        .clr   (redirect),
        .push  (keep),
        .pop   (pop_buf),
        .din   ({af_head, bus.i_rdata}),
        .dout  (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (bcount)
    );

    assign inst_valid = ~buf_empty;
    assign inst       = buf_head[inst_width-1:0];
    assign inst_pc    = buf_head[pc_width+inst_width-1:inst_width];

    logic unused_fifo_status;
    assign unused_fifo_status = ^{af_full, af_empty, af_count, buf_full};
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a request-queue / decode-stream model.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          disc;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst, inst_pc;
    logic        inst_valid, inst_ready, fetch_misaligned;

    always #5 clk = ~clk;

    fetch_unit_if #(.pc_width(32), .inst_width(32)) bus ();

    fetch_unit #(.pc_width(32), .pc_init(32'h0), .inst_width(32), .buf_depth(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .fetch_misaligned (fetch_misaligned)
    );

    int n_chk = 0, n_err = 0, cyc = 0, n_dec = 0;
    int k_rdy, k_rsp, k_lat, k_irdy, k_redir;
    req_t q[$];
    logic [31:0] exp_addr, exp_ipc, stale_addr, prev_addr, last_pc, force_pc;
    bit stale_pend, exp_mis, hold_prev, redir_prev, seen_wrap, force_redir;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus.i_raddr_ready = 1'b0;
        bus.i_rdata_valid = 1'b0;
        bus.i_rdata       = '0;
        redirect          = 1'b0;
        redirect_pc       = '0;
        inst_ready        = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_addr = 32'h0; exp_ipc = 32'h0;
        stale_pend = 0; exp_mis = 0; hold_prev = 0; redir_prev = 0; force_redir = 0;
        last_pc = 32'h0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.i_raddr_valid) break;
        end
        chk("first_valid", bus.i_raddr_valid, 1);
        chk("first_addr", bus.i_raddr, 32'h0);
    endtask

    task automatic step();
        logic ax, dx, decx;
        logic [31:0] tgt;
        int nd;
        req_t e;
        @(negedge clk);
        chk("rdata_ready", bus.i_rdata_ready, 1);
        if (redir_prev) chk("flush", inst_valid, 0);
        if (hold_prev) begin
            chk("hold_valid", bus.i_raddr_valid, 1);
            chk("hold_addr", bus.i_raddr, prev_addr);
        end
        nd = int'(stale_pend);
        foreach (q[i]) nd += int'(q[i].disc);
        chk("drain_quiet", bus.i_raddr_valid && !stale_pend && nd > 0, 0);
        chk("credit", q.size() <= DEPTH, 1);
        chk("misalign_flag", fetch_misaligned, exp_mis);

        bus.i_raddr_ready = ($urandom % 100) < k_rdy;
        bus.i_rdata_valid = 1'b0;
        bus.i_rdata       = $urandom;
        if (q.size() > 0 && q[0].due <= cyc && ($urandom % 100) < k_rsp) begin
            bus.i_rdata_valid = 1'b1;
            bus.i_rdata       = mem_word(q[0].addr);
        end
        inst_ready  = ($urandom % 100) < k_irdy;
        redirect    = force_redir || (($urandom % 1000) < k_redir);
        redirect_pc = force_redir ? force_pc :
                      (($urandom % 8 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
        force_redir = 0;

        ax   = bus.i_raddr_valid & bus.i_raddr_ready;
        dx   = bus.i_rdata_valid & bus.i_rdata_ready;
        decx = inst_valid & inst_ready;

        if (decx) begin
            chk("inst_pc", inst_pc, exp_ipc);
            chk("inst", inst, mem_word(inst_pc));
            if (inst_pc == 32'h0 && last_pc == 32'hFFFF_FFFC) seen_wrap = 1;
            last_pc = inst_pc;
            exp_ipc += 32'd4;
            n_dec++;
        end
        if (dx) void'(q.pop_front());
        if (ax) begin
            e.addr = bus.i_raddr;
            e.due  = cyc + 1 + $urandom_range(0, k_lat);
            if (stale_pend) begin
                chk("stale_addr", bus.i_raddr, stale_addr);
                e.disc = 1; stale_pend = 0;
            end else begin
                chk("addr", bus.i_raddr, exp_addr);
                e.disc = 0; exp_addr += 32'd4;
            end
            q.push_back(e);
        end
        if (redirect) begin
            tgt = redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) exp_mis = 1;
            tgt[1:0] = 2'b00;
`endif
            exp_addr = tgt;
            exp_ipc  = tgt;
            foreach (q[i]) q[i].disc = 1;
            if (bus.i_raddr_valid && !ax) begin
                stale_pend = 1; stale_addr = bus.i_raddr;
            end
        end
        hold_prev  = bus.i_raddr_valid & ~bus.i_raddr_ready;
        prev_addr  = bus.i_raddr;
        redir_prev = redirect;
        cyc++;
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();
        seen_wrap = 0;
        k_rdy = 0; k_rsp = 100; k_lat = 0; k_irdy = 100; k_redir = 0;
        repeat (3) @(negedge clk);
        chk("rst_raddr_valid", bus.i_raddr_valid, 0);
        chk("rst_raddr", bus.i_raddr, 32'h0);
        chk("rst_rdata_ready", bus.i_rdata_ready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misaligned", fetch_misaligned, 0);
        release_rst();

        // address held while the bus stalls
        repeat (5) begin
            step();
            chk("stall_valid", bus.i_raddr_valid, 1);
            chk("stall_addr", bus.i_raddr, 32'h0);
        end

        // streaming from pc_init
        k_rdy = 100;
        repeat (20) step();

        // decode stalled: buffer fills, fetch stops until a pop
        k_irdy = 0;
        repeat (8) step();
        chk("full_stop", bus.i_raddr_valid, 0);
        chk("full_inst_valid", inst_valid, 1);
        k_irdy = 100;
        step();
        for (int i = 0; i < 5; i++) begin
            if (bus.i_raddr_valid) break;
            step();
        end
        chk("resume", bus.i_raddr_valid, 1);

        // redirect with two requests in flight
        k_rsp = 0;
        repeat (6) step();
        chk("two_outstanding", q.size(), 2);
        force_redir = 1; force_pc = 32'h100;
        step();
        k_rsp = 100;
        step();
        for (int i = 0; i < 20; i++) begin
            if (inst_valid) break;
            step();
        end
        chk("redir_first_valid", inst_valid, 1);
        chk("redir_first_pc", inst_pc, 32'h100);

        // pc wrap
        force_redir = 1; force_pc = 32'hFFFF_FFF8;
        repeat (20) step();
        chk("wrap_seen", seen_wrap, 1);

        // misaligned redirect target
        force_redir = 1; force_pc = 32'h102;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            if (bus.i_raddr_valid && !stale_pend) break;
            step();
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_addr", bus.i_raddr, 32'h100);
        chk("mis_flag", fetch_misaligned, 1);
`else
        chk("mis_addr", bus.i_raddr, 32'h102);
        chk("mis_flag", fetch_misaligned, 0);
`endif
        repeat (10) step();

        // randomized traffic
        k_redir = 30;
        for (int b = 0; b < 10; b++) begin
            k_rdy  = $urandom_range(20, 100);
            k_rsp  = $urandom_range(30, 100);
            k_lat  = $urandom_range(0, 3);
            k_irdy = $urandom_range(20, 100);
            repeat (200) step();
        end

        // asynchronous reset mid-traffic
        #2 rst = 1'b0;
        #1;
        chk("arst_raddr_valid", bus.i_raddr_valid, 0);
        chk("arst_raddr", bus.i_raddr, 32'h0);
        chk("arst_rdata_ready", bus.i_rdata_ready, 0);
        chk("arst_inst_valid", inst_valid, 0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_inst_pc", inst_pc, 32'h0);
        chk("arst_misaligned", fetch_misaligned, 0);
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        release_rst();
        k_rdy = 100; k_rsp = 100; k_lat = 1; k_irdy = 100; k_redir = 0;
        repeat (30) step();
        chk("progress", n_dec > 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
